// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the PC, issues fetches to the 1-cycle-latency
// instruction ROM and buffers returned words with their PCs for decode.
// Ports:
//   clock, reset            - clock, async active-low reset
//   imem_addr/imem_req      - fetch request to inst_rom
//   imem_data               - ROM word, valid the cycle after imem_req
//   redirect_valid/_target  - branch/jump redirect, kills younger work
//   id_ready                - decode accepts the head entry
//   id_valid/id_instr/id_pc - queue head presented to decode
//   id_pc_next              - id_pc + PC_INC
//   misaligned              - pulse: last redirect target not word aligned
//   fetch_count             - saturating count of entries handed to decode
module fetch_queue_unit #(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = 'h0040_0000,
   parameter int unsigned        PC_INC   = 4,
   parameter int unsigned        QDEPTH   = 4,
   parameter int unsigned        PERF_W   = 16
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_req,
   input  logic [31:0]       imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              id_ready,
   output logic              id_valid,
   output logic [31:0]       id_instr,
   output logic [ADDR_W-1:0] id_pc,
   output logic [ADDR_W-1:0] id_pc_next,
   output logic              misaligned,
   output logic [PERF_W-1:0] fetch_count
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
   logic              inflight_q, inflight_d;
   logic              mis_q, mis_d;
   logic [PW-1:0]     rd_q, rd_d;
   logic [PW-1:0]     wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PERF_W-1:0] fcnt_q, fcnt_d;

   logic [31:0]       instr_mem_q [QDEPTH];
   logic [ADDR_W-1:0] pc_mem_q    [QDEPTH];

   logic              head_valid;
   logic              pop;
   logic              push;
   logic              issue;
   logic [CW:0]       demand;
   logic [ADDR_W-1:0] redir_pc;

   assign head_valid = (cnt_q != '0);
   assign pop        = head_valid && id_ready;
   assign redir_pc   = {redirect_target[ADDR_W-1:2], 2'b00};

   // Entries already owed to the queue after this cycle's pop; a new
   // fetch is only allowed when its return is guaranteed a slot.
   assign demand = {1'b0, cnt_q}
                 + {{CW{1'b0}}, inflight_q}
                 - {{CW{1'b0}}, pop};

   // Gated by reset so no request escapes while the core is held.
   assign issue = reset &&
                  (redirect_valid || (demand < (CW+1)'(QDEPTH)));

   // With a 1-cycle ROM, the only stale return a redirect can meet is
   // the one landing in the redirect cycle itself, so it is dropped here.
   assign push = inflight_q && !redirect_valid;

   assign imem_req  = issue;
   assign imem_addr = redirect_valid ? redir_pc : pc_q;

   always_comb begin
      pc_d       = pc_q;
      inflight_d = issue;
      ret_pc_d   = imem_addr;
      mis_d      = redirect_valid && (redirect_target[1:0] != 2'b00);
      rd_d       = rd_q;
      wr_d       = wr_q;
      cnt_d      = cnt_q;
      fcnt_d     = fcnt_q;

      if (redirect_valid) begin
         pc_d = redir_pc + INC;
      end else if (issue) begin
         pc_d = pc_q + INC;
      end

      if (redirect_valid) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (pop) rd_d = rd_q + PW'(1);
         if (push) wr_d = wr_q + PW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end

      if (pop && (fcnt_q != '1)) begin
         fcnt_d = fcnt_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         ret_pc_q   <= '0;
         inflight_q <= 1'b0;
         mis_q      <= 1'b0;
         rd_q       <= '0;
         wr_q       <= '0;
         cnt_q      <= '0;
         fcnt_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         ret_pc_q   <= ret_pc_d;
         inflight_q <= inflight_d;
         mis_q      <= mis_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
         fcnt_q     <= fcnt_d;
      end
   end

   // Storage needs no reset: entries are only visible through cnt_q.
   always_ff @(posedge clock) begin
      if (push) begin
         instr_mem_q[wr_q] <= imem_data;
         pc_mem_q[wr_q]    <= ret_pc_q;
      end
   end

   assign id_valid    = head_valid;
   assign id_instr    = head_valid ? instr_mem_q[rd_q] : '0;
   assign id_pc       = head_valid ? pc_mem_q[rd_q] : '0;
   assign id_pc_next  = head_valid ? (pc_mem_q[rd_q] + INC) : '0;
   assign misaligned  = mis_q;
   assign fetch_count = fcnt_q;

endmodule
